// File: rtl/ps2_host_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ps2_host_tx : PS/2 host-to-device command transmitter (RTS, frame, ACK,|
// | timeout). Optional macro PS2_TX_RETRY_EN: one retry on NACK/timeout.   |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk_sys,
   input  logic       clrn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err_timeout
);

   localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_REQ       = 3'd2,
      S_SHIFT     = 3'd3,
      S_WAIT_IDLE = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   // Index 0 carries ps2_clk, index 1 carries ps2_data.
   logic [1:0]    meta_q, sync_q, filt_q;
   logic [FW-1:0] fcnt_q [2];
   logic          fall_q;

   always_ff @(posedge clk_sys or negedge clrn) begin
      if (!clrn) begin
         meta_q    <= 2'b11;
         sync_q    <= 2'b11;
         filt_q    <= 2'b11;
         fcnt_q[0] <= '0;
         fcnt_q[1] <= '0;
         fall_q    <= 1'b0;
      end else begin
         meta_q <= {ps2_data_in, ps2_clk_in};
         sync_q <= meta_q;
         fall_q <= filt_q[0] & ~sync_q[0] & (fcnt_q[0] == FLT_LAST);
         for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FLT_LAST) begin
               filt_q[i] <= sync_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + 1'b1;
            end
         end
      end
   end

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic          parity_q, parity_d;
   logic [3:0]    bit_q, bit_d;
   logic [IW-1:0] inh_q, inh_d;
   logic [TW-1:0] to_q, to_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          ack_q, ack_d;
   logic          tmo_q, tmo_d;
   logic          start_retry;
   logic          w_can_retry;

`ifdef PS2_TX_RETRY_EN
   logic retry_q, retry_d;
   assign w_can_retry = ~retry_q;

   always_ff @(posedge clk_sys or negedge clrn) begin
      if (!clrn) retry_q <= 1'b0;
      else       retry_q <= retry_d;
   end
`else
   assign w_can_retry = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge clrn) begin
      if (!clrn) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         parity_q  <= 1'b0;
         bit_q     <= '0;
         inh_q     <= '0;
         to_q      <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ack_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         bit_q     <= bit_d;
         inh_q     <= inh_d;
         to_q      <= to_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         ack_q     <= ack_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      parity_d    = parity_q;
      bit_d       = bit_q;
      inh_d       = inh_q;
      to_d        = to_q;
      data_oe_d   = data_oe_q;
      ack_d       = ack_q;
      tmo_d       = tmo_q;
      start_retry = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d     = retry_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               data_d   = tx_data;
               parity_d = ~^tx_data;
               ack_d    = 1'b0;
               tmo_d    = 1'b0;
               inh_d    = '0;
               state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d  = 1'b0;
`endif
            end
         end
         S_INHIBIT: begin
            inh_d = inh_q + 1'b1;
            if (inh_q == INH_LAST) begin
               to_d    = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            bit_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (fall_q) begin
               bit_d = bit_q + 1'b1;
               if (bit_q < 4'd8) begin
                  data_oe_d = ~data_q[bit_q[2:0]];
               end else if (bit_q == 4'd8) begin
                  data_oe_d = ~parity_q;
               end else if (bit_q == 4'd9) begin
                  data_oe_d = 1'b0;
               end else begin
                  ack_d = ~sync_q[1];
                  if (sync_q[1] && w_can_retry) start_retry = 1'b1;
                  else                          state_d     = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (filt_q[0] && filt_q[1]) begin
               data_oe_d = 1'b0;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase

      // Timeout overrides whatever the edge logic decided this cycle.
      if (state_q inside {S_REQ, S_SHIFT, S_WAIT_IDLE}) begin
         if (to_q == TO_LAST) begin
            data_oe_d = 1'b0;
            ack_d     = 1'b0;
            if (w_can_retry) begin
               start_retry = 1'b1;
            end else begin
               tmo_d   = 1'b1;
               state_d = S_DONE;
            end
         end else begin
            to_d = to_q + 1'b1;
         end
      end

      if (start_retry) begin
         state_d = S_INHIBIT;
         inh_d   = '0;
         ack_d   = 1'b0;
         tmo_d   = 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_d = 1'b1;
`endif
      end

      // Start bit goes out in the final inhibit cycle.
      if (state_d == S_INHIBIT) data_oe_d = (inh_d == INH_LAST);
      clk_oe_d = (state_d == S_INHIBIT);
   end

   assign tx_ready    = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign ack_ok      = ack_q;
   assign err_timeout = (state_q == S_DONE) & tmo_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule
`default_nettype wire
